dcpl_sequencer: RTL and testbench

- Controller in front of the static-side decoupler chain. It sequences decoupling of the dynamic region for partial reconfiguration.
- On a decouple request it blocks new requests and waits until every shell channel is quiescent: no outstanding DMA reads or writes, no stream packet mid-flight.
- Only then does it raise the decouple level consumed by the decouplers. On release it drops decouple and holds a settle window before reporting active.
- Sits between the reconfiguration control register and the decouple input of the static decoupling stage.

---
 rtl/dcpl_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_dcpl_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpl_sequencer.sv
// Decouple sequencer for partial reconfiguration: drains the shell channels, then isolates the region.
// Optional drain timeout enabled by defining DCPL_TIMEOUT_EN.
module dcpl_sequencer #(
  parameter int N_CHAN         = 2,
  parameter int CNT_BITS       = 6,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              xclk,
  input  logic              xresetn,
  input  logic              s_decouple_req,
  input  logic [N_CHAN-1:0] rd_req_hs,
  input  logic [N_CHAN-1:0] rd_done,
  input  logic [N_CHAN-1:0] wr_req_hs,
  input  logic [N_CHAN-1:0] wr_done,
  input  logic [N_CHAN-1:0] axis_in_beat,
  input  logic [N_CHAN-1:0] axis_in_last,
  input  logic [N_CHAN-1:0] axis_out_beat,
  input  logic [N_CHAN-1:0] axis_out_last,
  output logic              m_req_block,
  output logic              m_decouple,
  output logic              m_decoupled,
  output logic              m_busy,
  output logic              m_timeout,
  input  logic              s_timeout_clr
);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam int                  SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]    SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX     = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO    = {CNT_BITS{1'b0}};

  // Outstanding-request counter: saturates at both ends, a coincident req/done is a no-op
  function automatic logic [CNT_BITS-1:0] cnt_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic [CNT_BITS-1:0] res;
    if (inc && !dec && (cnt != CNT_MAX))       res = cnt + CNT_BITS'(1);
    else if (dec && !inc && (cnt != CNT_ZERO)) res = cnt - CNT_BITS'(1);
    else                                       res = cnt;
    return res;
  endfunction

  state_t              r_state;
  logic [CNT_BITS-1:0] r_rd_cnt [N_CHAN];
  logic [CNT_BITS-1:0] r_wr_cnt [N_CHAN];
  logic [N_CHAN-1:0]   r_in_open;
  logic [N_CHAN-1:0]   r_out_open;
  logic                r_idle;
  logic                r_idle_q;
  logic [SET_W-1:0]    r_settle;
  logic                w_cnt_busy;
  logic                w_quiet;
  logic                w_track;
  logic                w_clear;
  logic                w_expired;
  logic                w_drain_done;

  // Quiescence of all channels as seen in the current cycle
  always_comb begin
    w_cnt_busy = 1'b0;
    for (int c = 0; c < N_CHAN; c++) begin
      w_cnt_busy = w_cnt_busy | (r_rd_cnt[c] != CNT_ZERO) | (r_wr_cnt[c] != CNT_ZERO);
    end
    w_quiet = !w_cnt_busy && (r_in_open == {N_CHAN{1'b0}}) && (r_out_open == {N_CHAN{1'b0}}) &&
              ((rd_req_hs | wr_req_hs | axis_in_beat | axis_out_beat) == {N_CHAN{1'b0}});
  end

  assign w_track      = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
  assign w_clear      = (r_state == ST_DECOUPLED) && !s_decouple_req;
  assign w_drain_done = (r_idle && r_idle_q) || w_expired;

  // Channel monitors; frozen while isolated, wiped when the region is released
  always_ff @(posedge xclk or negedge xresetn) begin
    if (!xresetn) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_rd_cnt[c] <= CNT_ZERO;
        r_wr_cnt[c] <= CNT_ZERO;
      end
      r_in_open  <= {N_CHAN{1'b0}};
      r_out_open <= {N_CHAN{1'b0}};
    end else if (w_clear) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_rd_cnt[c] <= CNT_ZERO;
        r_wr_cnt[c] <= CNT_ZERO;
      end
      r_in_open  <= {N_CHAN{1'b0}};
      r_out_open <= {N_CHAN{1'b0}};
    end else if (w_track) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_rd_cnt[c]   <= cnt_step(r_rd_cnt[c], rd_req_hs[c], rd_done[c]);
        r_wr_cnt[c]   <= cnt_step(r_wr_cnt[c], wr_req_hs[c], wr_done[c]);
        r_in_open[c]  <= axis_in_beat[c]  ? !axis_in_last[c]  : r_in_open[c];
        r_out_open[c] <= axis_out_beat[c] ? !axis_out_last[c] : r_out_open[c];
      end
    end
  end

  // Idle history only accumulates inside DRAIN, so a fresh drain always waits two idle samples
  always_ff @(posedge xclk or negedge xresetn) begin
    if (!xresetn) begin
      r_idle   <= 1'b0;
      r_idle_q <= 1'b0;
    end else begin
      r_idle   <= (r_state == ST_DRAIN) && w_quiet;
      r_idle_q <= (r_state == ST_DRAIN) && r_idle;
    end
  end

`ifdef DCPL_TIMEOUT_EN
  localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_timeout;

  assign w_expired = (r_state == ST_DRAIN) && (r_tmr == TMR_LAST);
  assign m_timeout = r_timeout;

  // Drain timer and sticky timeout flag; a coincident clear loses to a new timeout
  always_ff @(posedge xclk or negedge xresetn) begin
    if (!xresetn) begin
      r_tmr     <= {TMR_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_tmr <= (r_state == ST_DRAIN) ? (r_tmr + TMR_W'(1)) : {TMR_W{1'b0}};
      if (w_expired && s_decouple_req) r_timeout <= 1'b1;
      else if (s_timeout_clr)          r_timeout <= 1'b0;
    end
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = s_timeout_clr;
  assign w_expired    = 1'b0;
  assign m_timeout    = 1'b0;
`endif

  // Sequencer FSM; outputs are updated on the same edge as the state they describe
  always_ff @(posedge xclk or negedge xresetn) begin
    if (!xresetn) begin
      r_state     <= ST_ACTIVE;
      r_settle    <= {SET_W{1'b0}};
      m_req_block <= 1'b0;
      m_decouple  <= 1'b0;
      m_decoupled <= 1'b0;
      m_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (s_decouple_req) begin
            r_state     <= ST_DRAIN;
            m_req_block <= 1'b1;
            m_busy      <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!s_decouple_req) begin
            r_state     <= ST_ACTIVE;
            m_req_block <= 1'b0;
            m_busy      <= 1'b0;
          end else if (w_drain_done) begin
            r_state     <= ST_DECOUPLED;
            m_decouple  <= 1'b1;
            m_decoupled <= 1'b1;
            m_busy      <= 1'b0;
          end
        end
        ST_DECOUPLED: begin
          if (!s_decouple_req) begin
            r_state     <= ST_RELEASE;
            r_settle    <= SETTLE_LOAD;
            m_decouple  <= 1'b0;
            m_decoupled <= 1'b0;
            m_busy      <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_settle == {SET_W{1'b0}}) begin
            r_state     <= ST_ACTIVE;
            m_req_block <= 1'b0;
            m_busy      <= 1'b0;
          end else begin
            r_settle <= r_settle - SET_W'(1);
          end
        end
        default: begin
          r_state     <= ST_ACTIVE;
          r_settle    <= {SET_W{1'b0}};
          m_req_block <= 1'b0;
          m_decouple  <= 1'b0;
          m_decoupled <= 1'b0;
          m_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcpl_sequencer.sv
// Self-checking bench for dcpl_sequencer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the drain/isolate/settle protocol.
module tb_dcpl_sequencer;
  localparam int N    = 2;
  localparam int SET  = 4;
  localparam int TO   = 64;
  localparam int CMAX = 63;
`ifdef DCPL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int PH_RUN = 0, PH_DRAIN = 1, PH_ISO = 2, PH_SETTLE = 3;

  logic         xclk = 1'b0, xresetn = 1'b0, s_decouple_req = 1'b0, s_timeout_clr = 1'b0;
  logic [N-1:0] rd_req_hs = '0, rd_done = '0, wr_req_hs = '0, wr_done = '0;
  logic [N-1:0] axis_in_beat = '0, axis_in_last = '0, axis_out_beat = '0, axis_out_last = '0;
  logic         m_req_block, m_decouple, m_decoupled, m_busy, m_timeout;

  always #5 xclk = ~xclk;

  dcpl_sequencer #(.N_CHAN(N), .CNT_BITS(6), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .xclk(xclk), .xresetn(xresetn), .s_decouple_req(s_decouple_req),
    .rd_req_hs(rd_req_hs), .rd_done(rd_done), .wr_req_hs(wr_req_hs), .wr_done(wr_done),
    .axis_in_beat(axis_in_beat), .axis_in_last(axis_in_last),
    .axis_out_beat(axis_out_beat), .axis_out_last(axis_out_last),
    .m_req_block(m_req_block), .m_decouple(m_decouple), .m_decoupled(m_decoupled),
    .m_busy(m_busy), .m_timeout(m_timeout), .s_timeout_clr(s_timeout_clr));

  int n_checks = 0, n_pass = 0;

  // reference model: outstanding work per channel plus the protocol phase
  int md_rd[N], md_wr[N];
  bit md_in[N], md_out[N];
  int md_ph, md_streak, md_settle, md_age;
  bit md_to;

  function automatic int clampc(int v);
    if (v < 0) return 0;
    if (v > CMAX) return CMAX;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      md_rd[c] = 0; md_wr[c] = 0; md_in[c] = 1'b0; md_out[c] = 1'b0;
    end
    md_ph = PH_RUN; md_streak = 0; md_settle = 0; md_age = 0; md_to = 1'b0;
  endfunction

  function automatic void model_edge();
    bit quiet, to_set;
    int nxt;
    to_set = 1'b0;
    quiet = (md_ph == PH_DRAIN) && ((rd_req_hs | wr_req_hs | axis_in_beat | axis_out_beat) == '0);
    for (int c = 0; c < N; c++)
      if (md_rd[c] != 0 || md_wr[c] != 0 || md_in[c] || md_out[c]) quiet = 1'b0;
    if (md_ph == PH_RUN || md_ph == PH_DRAIN) begin
      for (int c = 0; c < N; c++) begin
        md_rd[c] = clampc(md_rd[c] + int'(rd_req_hs[c]) - int'(rd_done[c]));
        md_wr[c] = clampc(md_wr[c] + int'(wr_req_hs[c]) - int'(wr_done[c]));
        if (axis_in_beat[c])  md_in[c]  = !axis_in_last[c];
        if (axis_out_beat[c]) md_out[c] = !axis_out_last[c];
      end
    end
    nxt = md_ph;
    case (md_ph)
      PH_RUN: if (s_decouple_req) begin nxt = PH_DRAIN; md_age = 0; end
      PH_DRAIN: begin
        if (!s_decouple_req) nxt = PH_RUN;
        else if (md_streak >= 2 || (TO_EN && md_age == TO - 1)) begin
          nxt = PH_ISO;
          to_set = TO_EN && (md_age == TO - 1);
        end else md_age++;
      end
      PH_ISO: if (!s_decouple_req) begin
        nxt = PH_SETTLE; md_settle = SET - 1;
        for (int c = 0; c < N; c++) begin
          md_rd[c] = 0; md_wr[c] = 0; md_in[c] = 1'b0; md_out[c] = 1'b0;
        end
      end
      default: if (md_settle == 0) nxt = PH_RUN; else md_settle--;
    endcase
    if (to_set) md_to = 1'b1;
    else if (s_timeout_clr) md_to = 1'b0;
    md_streak = quiet ? md_streak + 1 : 0;
    md_ph = nxt;
  endfunction

  function automatic logic [4:0] exp_vec();
    return {md_ph != PH_RUN, md_ph == PH_ISO, md_ph == PH_ISO,
            (md_ph == PH_DRAIN) || (md_ph == PH_SETTLE), md_to};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {m_req_block, m_decouple, m_decoupled, m_busy, m_timeout};
  endfunction

  task automatic tick();
    @(posedge xclk);
    model_edge();
    #1;
    rd_req_hs = '0; rd_done = '0; wr_req_hs = '0; wr_done = '0;
    axis_in_beat = '0; axis_in_last = '0; axis_out_beat = '0; axis_out_last = '0;
    s_timeout_clr = 1'b0;
  endtask

  task automatic test_reset();
    xresetn = 1'b0; model_reset();
    repeat (2) @(posedge xclk);
    #1;
    n_checks++;
    if (obs_vec() !== 5'b00000) $display("FAIL reset_hold got=%b want=00000", obs_vec());
    else n_pass++;
    @(negedge xclk); xresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== 5'b00000 || exp_vec() !== 5'b00000)
        $display("FAIL reset_idle i=%0d got=%b want=00000", i, obs_vec());
      else n_pass++;
    end
  endtask

  task automatic test_drain_read();
    for (int i = 0; i < 3; i++) begin rd_req_hs[0] = 1'b1; tick(); end
    s_decouple_req = 1'b1; tick();
    n_checks++;
    if (obs_vec() !== 5'b10010) $display("FAIL drain_block got=%b want=10010", obs_vec());
    else n_pass++;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 9; k++) begin
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL drain_wait d=%0d k=%0d got=%b want=%b", d, k, obs_vec(), exp_vec());
        else n_pass++;
      end
      rd_done[0] = 1'b1; tick();
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (m_decouple !== 1'b0) $display("FAIL drain_early k=%0d got=%b want=0", k, m_decouple);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL drain_decouple got=%b want=11100", obs_vec());
    else n_pass++;
  endtask

  task automatic test_release();
    s_decouple_req = 1'b0; tick();
    n_checks++;
    if (obs_vec() !== 5'b10010) $display("FAIL release_entry got=%b want=10010", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== 5'b10010) $display("FAIL release_busy k=%0d got=%b want=10010", k, obs_vec());
      else n_pass++;
    end
    tick();
    n_checks++;
    if (obs_vec() !== 5'b00000) $display("FAIL release_active got=%b want=00000", obs_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (obs_vec() !== 5'b10010) $display("FAIL release_redrain got=%b want=10010", obs_vec());
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL release_min_latency got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (obs_vec() !== 5'b00000 || exp_vec() !== 5'b00000) $display("FAIL release_done got=%b want=00000", obs_vec());
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin axis_in_beat[1] = 1'b1; axis_in_last[1] = 1'b0; tick(); end
    s_decouple_req = 1'b1; tick();
    for (int k = 0; k < 19; k++) begin
      tick();
      n_checks++;
      if (m_decouple !== 1'b0 || obs_vec() !== exp_vec())
        $display("FAIL stream_hold k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    axis_in_beat[1] = 1'b1; axis_in_last[1] = 1'b1; tick();
    repeat (2) tick();
    n_checks++;
    if (m_decouple !== 1'b0) $display("FAIL stream_early got=%b want=0", m_decouple);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL stream_decouple got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_counter_edges();
    for (int i = 0; i < 2; i++) begin wr_req_hs[0] = 1'b1; tick(); end
    wr_req_hs[0] = 1'b1; wr_done[0] = 1'b1; tick();
    rd_done[1] = 1'b1; tick();
    s_decouple_req = 1'b1; tick();
    repeat (8) tick();
    wr_done[0] = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (m_decouple !== 1'b0 || obs_vec() !== exp_vec())
        $display("FAIL cnt_coincident k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    wr_done[0] = 1'b1; tick();
    repeat (3) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL cnt_drained got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0; repeat (5) tick();
    for (int i = 0; i < 70; i++) begin rd_req_hs[1] = 1'b1; tick(); end
    for (int i = 0; i < 62; i++) begin rd_done[1] = 1'b1; tick(); end
    s_decouple_req = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (m_decouple !== 1'b0 || obs_vec() !== exp_vec())
        $display("FAIL cnt_saturate k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    rd_done[1] = 1'b1; tick();
    repeat (3) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL cnt_sat_drained got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0; repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    s_decouple_req = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL rstmid_pre got=%b want=11100", obs_vec());
    else n_pass++;
    #2 xresetn = 1'b0; model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 5'b00000) $display("FAIL rstmid_async got=%b want=00000", obs_vec());
    else n_pass++;
    @(posedge xclk); @(negedge xclk); xresetn = 1'b1;
    tick();
    n_checks++;
    if (obs_vec() !== 5'b10010) $display("FAIL rstmid_redrain got=%b want=10010", obs_vec());
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL rstmid_clean got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0; repeat (5) tick();
  endtask

`ifdef DCPL_TIMEOUT_EN
  task automatic test_timeout();
    rd_req_hs[0] = 1'b1; tick();
    s_decouple_req = 1'b1; tick();
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== 5'b10010) $display("FAIL timeout_early k=%0d got=%b want=10010", k, obs_vec());
      else n_pass++;
    end
    s_timeout_clr = 1'b1; tick();
    n_checks++;
    if (obs_vec() !== 5'b11101) $display("FAIL timeout_fire got=%b want=11101", obs_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (obs_vec() !== 5'b11101) $display("FAIL timeout_sticky got=%b want=11101", obs_vec());
    else n_pass++;
    s_timeout_clr = 1'b1; tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL timeout_clear got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0; repeat (5) tick();
    s_decouple_req = 1'b1; repeat (4) tick();
    n_checks++;
    if (obs_vec() !== 5'b11100) $display("FAIL timeout_fresh got=%b want=11100", obs_vec());
    else n_pass++;
    s_decouple_req = 1'b0; repeat (5) tick();
  endtask
`else
  task automatic test_no_timeout();
    rd_req_hs[0] = 1'b1; tick();
    s_decouple_req = 1'b1; tick();
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (k % 100 == 99) begin
        n_checks++;
        if (obs_vec() !== 5'b10010) $display("FAIL no_timeout k=%0d got=%b want=10010", k, obs_vec());
        else n_pass++;
      end
    end
    s_decouple_req = 1'b0; tick();
    n_checks++;
    if (obs_vec() !== 5'b00000) $display("FAIL drain_abort got=%b want=00000", obs_vec());
    else n_pass++;
    rd_done[0] = 1'b1; tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) s_decouple_req = !s_decouple_req;
      for (int c = 0; c < N; c++) begin
        rd_req_hs[c]     = ($urandom_range(0, 15) == 0);
        rd_done[c]       = ($urandom_range(0, 3) == 0);
        wr_req_hs[c]     = ($urandom_range(0, 15) == 0);
        wr_done[c]       = ($urandom_range(0, 3) == 0);
        axis_in_beat[c]  = ($urandom_range(0, 7) == 0);
        axis_in_last[c]  = ($urandom_range(0, 1) == 1);
        axis_out_beat[c] = ($urandom_range(0, 7) == 0);
        axis_out_last[c] = ($urandom_range(0, 1) == 1);
      end
      s_timeout_clr = ($urandom_range(0, 19) == 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_drain_read();
    test_release();
    test_stream();
    test_counter_edges();
    test_reset_mid();
`ifdef DCPL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
